// File: rtl/fifo_pixel_reader.sv
// Read-side controller for the pixel async FIFO: drains one IMG_W*IMG_H frame
// per start pulse into a valid/ready stream with sof/eol/eof markers.
`timescale 1ns/1ps
module fifo_pixel_reader #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic              fifo_rst_busy,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic              frame_done
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int NW   = $clog2(NPIX + 1);
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [NW-1:0] LAST_ISSUE = NW'(NPIX - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sof;
        logic              eol;
        logic              eof;
    } entry_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   issued_q, issued_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            inflight_q;
    logic [1:0]      occ_q, occ_d;
    entry_t          skid_q [2];
    entry_t          skid_d [2];
    entry_t          cap;
    logic            push, pop;
    logic [2:0]      load;

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;
    assign m_data  = skid_q[0].data;
    assign m_sof   = m_valid & skid_q[0].sof;
    assign m_eol   = m_valid & skid_q[0].eol;
    assign m_eof   = m_valid & skid_q[0].eof;

    // Occupancy is taken after this cycle's pop so a full-rate stream never bubbles.
    assign load = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (fifo_rd_en && issued_q == LAST_ISSUE) state_d = DRAIN;
            DRAIN:   if (pop && skid_q[0].eof) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        fifo_rd_en = (state_q == RUN) && !fifo_empty && !fifo_rst_busy && (load < 3'd2);
        frame_done = (state_q == DRAIN) && pop && skid_q[0].eof;
    end

    always_comb begin
        issued_d = (state_q == IDLE) ? '0 : issued_q + NW'(fifo_rd_en);
        col_d    = col_q;
        row_d    = row_q;
        if (push) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        cap.data = fifo_dout;
        cap.sof  = (col_q == '0) && (row_q == '0);
        cap.eol  = (col_q == COL_LAST);
        cap.eof  = (col_q == COL_LAST) && (row_q == ROW_LAST);

        skid_d[0] = skid_q[0];
        skid_d[1] = skid_q[1];
        occ_d     = occ_q;
        case ({push, pop})
            2'b10: begin
                skid_d[occ_q[0]] = cap;
                occ_d            = occ_q + 2'd1;
            end
            2'b01: begin
                skid_d[0] = skid_q[1];
                occ_d     = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = cap;
                end else begin
                    skid_d[0] = cap;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
        end else begin
            issued_q   <= issued_d;
            col_q      <= col_d;
            row_q      <= row_d;
            inflight_q <= fifo_rd_en;
            occ_q      <= occ_d;
            skid_q[0]  <= skid_d[0];
            skid_q[1]  <= skid_d[1];
        end
    end

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Directed bench for fifo_pixel_reader with a 1-cycle-latency FIFO model (IMG_W=4, IMG_H=2).
`timescale 1ns/1ps
module tb_fifo_pixel_reader;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;

    logic          rd_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty;
    logic          fifo_rst_busy = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic          m_sof, m_eol, m_eof, busy, frame_done;

    always #5 rd_clk = ~rd_clk;

    fifo_pixel_reader #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .start(start),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rst_busy(fifo_rst_busy),
        .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .busy(busy), .frame_done(frame_done)
    );

    // FIFO model: standard mode, dout updates the cycle after rd_en
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge rd_clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int ready_mode = 0;
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge rd_clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // Monitor: records accepted pixels, counts rd_en, and tracks an independent occupancy model
    logic [7:0]  got_d [$];
    logic [3:0]  got_f [$];
    int          got_c [$];
    int          cyc = 0, rd_cnt = 0, done_cnt = 0, viol = 0;
    int          occ_m = 0, infl_m = 0, acc_m = 0;
    int          busy_fall = -1, done_cyc = -2;
    logic        prev_stall = 1'b0, prev_busy = 1'b0;
    logic [10:0] prev_out = '0;

    initial begin
        forever begin
            @(negedge rd_clk);
            cyc++;
            if (!rst_n) begin
                occ_m = 0; infl_m = 0; prev_stall = 1'b0;
            end else begin
                acc_m = (m_valid && m_ready) ? 1 : 0;
                if (m_valid !== (occ_m != 0)) viol++;
                if (fifo_rd_en && (fifo_empty || fifo_rst_busy || occ_m + infl_m - acc_m >= 2)) viol++;
                if (prev_stall && ({m_data, m_sof, m_eol, m_eof} !== prev_out)) viol++;
                if (fifo_rd_en) rd_cnt++;
                if (frame_done) begin done_cnt++; done_cyc = cyc; end
                if (acc_m != 0) begin
                    got_d.push_back(m_data);
                    got_f.push_back({m_sof, m_eol, m_eof, frame_done});
                    got_c.push_back(cyc);
                end
                prev_stall = m_valid && !m_ready;
                prev_out   = {m_data, m_sof, m_eol, m_eof};
                occ_m      = occ_m + infl_m - acc_m;
                if (occ_m > 2) viol++;
                infl_m     = fifo_rd_en ? 1 : 0;
            end
            if (prev_busy && !busy) busy_fall = cyc;
            prev_busy = busy;
        end
    end

    int checks = 0;
    int errors = 0;
    // {sof, eol, eof, frame_done} for pixels 0..7 of a 4x2 frame
    logic [3:0] EXPF [8] = '{4'b1000, 4'b0000, 4'b0000, 4'b0100,
                             4'b0000, 4'b0000, 4'b0000, 4'b0111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge rd_clk); #1; end
    endtask

    task automatic preload(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = base + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin tick(1); n++; end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_pix(input int idx0, input int n, input string tag);
        int k;
        k = 0;
        while (got_d.size() < idx0 + n && k < 400) begin tick(1); k++; end
        chk({tag, "_pix"}, (got_d.size() >= idx0 + n), 1);
    endtask

    task automatic check_frame(input string tag, input int idx0, input logic [7:0] base);
        logic [7:0] d;
        logic [3:0] f;
        for (int i = 0; i < 8; i++) begin
            d = (idx0 + i < got_d.size()) ? got_d[idx0 + i] : 8'hxx;
            f = (idx0 + i < got_f.size()) ? got_f[idx0 + i] : 4'hx;
            chk($sformatf("%s_data%0d", tag, i), d, base + 8'(i));
            chk($sformatf("%s_flag%0d", tag, i), f, EXPF[i]);
        end
    endtask

    initial begin
        int i0, i1, r0, v0, d0, eofs;
        #500000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int i0, i1, r0, v0, d0, eofs;
        rst_n = 1'b0;
        tick(2);
        chk("rst_out", {m_valid, fifo_rd_en, busy, m_sof, m_eol, m_eof, frame_done, m_data}, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 0);

        // 1: full rate
        i0 = got_d.size(); r0 = rd_cnt; v0 = viol;
        preload(8'h00, 8);
        pulse_start();
        wait_idle("t1");
        tick(2);
        check_frame("t1", i0, 8'h00);
        chk("t1_cnt", got_d.size() - i0, 8);
        chk("t1_rd", rd_cnt - r0, 8);
        chk("t1_consec", got_c[i0 + 7] - got_c[i0], 7);
        chk("t1_busyfall", busy_fall, done_cyc + 1);
        chk("t1_viol", viol - v0, 0);

        // 2: ready 1,0,0 pattern
        ready_mode = 1;
        i0 = got_d.size(); r0 = rd_cnt; v0 = viol;
        preload(8'h10, 8);
        pulse_start();
        wait_idle("t2");
        tick(2);
        check_frame("t2", i0, 8'h10);
        chk("t2_cnt", got_d.size() - i0, 8);
        chk("t2_rd", rd_cnt - r0, 8);
        chk("t2_viol", viol - v0, 0);
        ready_mode = 0;
        tick(2);

        // 3: FIFO runs empty after the third pixel
        i0 = got_d.size(); v0 = viol;
        preload(8'h20, 3);
        pulse_start();
        wait_pix(i0, 3, "t3_first3");
        r0 = rd_cnt;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_gap_rd%0d", k), fifo_rd_en, 0);
            tick(1);
        end
        chk("t3_gap_rdcnt", rd_cnt - r0, 0);
        chk("t3_gap_valid", m_valid, 0);
        preload(8'h23, 5);
        wait_idle("t3");
        tick(2);
        check_frame("t3", i0, 8'h20);
        chk("t3_cnt", got_d.size() - i0, 8);
        chk("t3_viol", viol - v0, 0);

        // 4: rd_rst_busy holds reads; start during a frame is ignored
        i0 = got_d.size(); v0 = viol;
        fifo_rst_busy = 1'b1;
        preload(8'h30, 8);
        r0 = rd_cnt;
        pulse_start();
        tick(6);
        chk("t4_hold_rd", rd_cnt - r0, 0);
        chk("t4_hold_busy", busy, 1);
        chk("t4_hold_valid", m_valid, 0);
        fifo_rst_busy = 1'b0;
        tick(3);
        chk("t4_busy_at_start", busy, 1);
        pulse_start();
        wait_idle("t4");
        tick(10);
        check_frame("t4", i0, 8'h30);
        chk("t4_cnt", got_d.size() - i0, 8);
        chk("t4_rd", rd_cnt - r0, 8);
        chk("t4_no_rearm", busy, 0);
        chk("t4_viol", viol - v0, 0);

        // 5: reset mid-frame with a read in flight
        i0 = got_d.size();
        preload(8'h40, 8);
        pulse_start();
        wait_pix(i0, 3, "t5_first3");
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out", {m_valid, fifo_rd_en, busy, m_sof, m_eol, m_eof, frame_done, m_data}, 0);
        tick(2);
        rst_n = 1'b1;
        flush = 1'b1; tick(1); flush = 1'b0;
        tick(4);
        chk("t5_idle_valid", m_valid, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_rd", fifo_rd_en, 0);
        i1 = got_d.size(); v0 = viol;
        preload(8'h50, 8);
        pulse_start();
        wait_idle("t5");
        tick(2);
        check_frame("t5", i1, 8'h50);
        chk("t5_cnt", got_d.size() - i1, 8);
        chk("t5_viol", viol - v0, 0);

        // 6: back-to-back frames with random backpressure
        ready_mode = 2;
        i0 = got_d.size(); v0 = viol; d0 = done_cnt; r0 = rd_cnt;
        preload(8'h60, 16);
        pulse_start();
        wait_idle("t6a");
        pulse_start();
        wait_idle("t6b");
        tick(3);
        check_frame("t6a", i0, 8'h60);
        check_frame("t6b", i0 + 8, 8'h68);
        eofs = 0;
        for (int k = i0; k < got_f.size(); k++) eofs += int'(got_f[k][1]);
        chk("t6_eofs", eofs, 2);
        chk("t6_done", done_cnt - d0, 2);
        chk("t6_rd", rd_cnt - r0, 16);
        chk("t6_viol", viol - v0, 0);
        ready_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
